// File: rtl/i2s_dac_serializer.sv
// I2S serializer for the WM8731 DAC: divides the system clock into BCLK/DACLRCK and shifts out
// one {L,R} frame per LRCK period. Define UNDERRUN_HOLD_EN to repeat the last frame on underrun.
module i2s_dac_serializer #(
  parameter int BCLK_HALF = 6,
  parameter int SLOT_W    = 16
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [SLOT_W-1:0] in_left,
  input  logic [SLOT_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              sample_tick,
  output logic              underrun
);
  localparam int FRAME_W = 2*SLOT_W;
  localparam int DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int CNT_W   = $clog2(FRAME_W);

  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt, bit_nxt, bit_idx;
  logic [FRAME_W-1:0] hold_buf, frame, ur_frame;
  logic               buf_full, wrap, fall, load, wr;

  assign wrap     = (div_cnt == DIV_W'(BCLK_HALF-1));
  assign fall     = wrap & aud_bclk;
  assign bit_nxt  = (bit_cnt == CNT_W'(FRAME_W-1)) ? '0 : bit_cnt + 1'b1;
  assign load     = fall & (bit_nxt == '0);
  // Bit 0 of a new frame still carries the previous frame's LSB (one-BCLK I2S delay).
  assign bit_idx  = (bit_nxt == '0) ? '0 : CNT_W'(FRAME_W) - bit_nxt;
  assign in_ready = ~buf_full;
  assign wr       = in_valid & in_ready;

`ifdef UNDERRUN_HOLD_EN
  assign ur_frame = frame;
`else
  assign ur_frame = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= CNT_W'(FRAME_W-1);
      aud_daclrck <= 1'b1;
      aud_dacdat  <= 1'b0;
    end else if (fall) begin
      bit_cnt    <= bit_nxt;
      aud_dacdat <= frame[bit_idx];
      if (bit_nxt == '0)
        aud_daclrck <= 1'b0;
      else if (bit_nxt == CNT_W'(SLOT_W))
        aud_daclrck <= 1'b1;
    end
  end

  // A write in the load clock finds the buffer empty, so it is kept for the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_buf <= '0;
      buf_full <= 1'b0;
      frame    <= '0;
    end else begin
      if (wr) begin
        hold_buf <= {in_left, in_right};
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      if (load)
        frame <= buf_full ? hold_buf : ur_frame;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= load;
      underrun    <= load & ~buf_full;
    end
  end
endmodule
